// File: rtl/led_output_driver_pkg.sv
// Shared definitions for the LED output driver: mode encodings, FSM states,
// period field width and the effective-period helper.
package led_output_driver_pkg;

    localparam int PERIOD_W = 10;

    typedef enum logic [1:0] {
        LED_MODE_OFF     = 2'd0,
        LED_MODE_ON      = 2'd1,
        LED_MODE_BLINK   = 2'd2,
        LED_MODE_BREATHE = 2'd3
    } led_mode_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_APPLY = 1'b1
    } fsm_state_e;

    // A period of zero behaves as one tick so that blink/breathe always advance.
    function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] period);
        logic [PERIOD_W-1:0] result;
        if (period == PERIOD_W'(0)) begin
            result = PERIOD_W'(1);
        end else begin
            result = period;
        end
        return result;
    endfunction

endpackage

// File: rtl/led_output_driver_channel.sv
// One LED channel: command registers, blink/breathe timing and PWM compare.
// Breathe ramp hardware exists only when LED_BREATHE_EN is defined.
module led_output_driver_channel
    import led_output_driver_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic                wr,
    input  logic [1:0]          mode,
    input  logic [PWM_BITS-1:0] level,
    input  logic [PERIOD_W-1:0] period,
    output logic                lit
);

    led_mode_e           mode_r;
    logic [PWM_BITS-1:0] level_r;
    logic [PERIOD_W-1:0] period_r;
    logic                phase_r;
    logic [PERIOD_W-1:0] tick_cnt_r;
    logic                step_s;
    logic                timed_s;
    logic [PWM_BITS-1:0] duty_s;

    assign timed_s = (mode_r == LED_MODE_BLINK) || (mode_r == LED_MODE_BREATHE);
    assign step_s  = tick && timed_s && (tick_cnt_r == (eff_period(period_r) - PERIOD_W'(1)));

    // Channel configuration, written only by the APPLY strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_r   <= LED_MODE_OFF;
            level_r  <= '0;
            period_r <= '0;
        end else if (wr) begin
            mode_r   <= led_mode_e'(mode);
            level_r  <= level;
            period_r <= period;
        end
    end

    // Tick counter and blink phase; a fresh command restarts both in the on phase.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_r <= '0;
            phase_r    <= 1'b0;
        end else if (wr) begin
            tick_cnt_r <= '0;
            phase_r    <= 1'b1;
        end else if (step_s) begin
            tick_cnt_r <= '0;
            phase_r    <= (mode_r == LED_MODE_BLINK) ? ~phase_r : phase_r;
        end else if (tick && timed_s) begin
            tick_cnt_r <= tick_cnt_r + PERIOD_W'(1);
        end
    end

`ifdef LED_BREATHE_EN
    logic [PWM_BITS-1:0] ramp_r;
    logic                dir_down_r;

    // Triangle ramp 0 -> level -> 0; direction flips on reaching either end.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ramp_r     <= '0;
            dir_down_r <= 1'b0;
        end else if (wr) begin
            ramp_r     <= '0;
            dir_down_r <= 1'b0;
        end else if (step_s && (mode_r == LED_MODE_BREATHE)) begin
            if (!dir_down_r) begin
                if (ramp_r < level_r) begin
                    ramp_r     <= ramp_r + PWM_BITS'(1);
                    dir_down_r <= (ramp_r == (level_r - PWM_BITS'(1)));
                end
            end else if (ramp_r != PWM_BITS'(0)) begin
                ramp_r     <= ramp_r - PWM_BITS'(1);
                dir_down_r <= (ramp_r != PWM_BITS'(1));
            end
        end
    end
`endif

    // Duty selection by mode.
    always_comb begin
        duty_s = '0;
        case (mode_r)
            LED_MODE_OFF:   duty_s = '0;
            LED_MODE_ON:    duty_s = level_r;
            LED_MODE_BLINK: duty_s = phase_r ? level_r : '0;
`ifdef LED_BREATHE_EN
            LED_MODE_BREATHE: duty_s = ramp_r;
`else
            LED_MODE_BREATHE: duty_s = level_r;
`endif
            default:        duty_s = '0;
        endcase
    end

    assign lit = (duty_s > pwm_cnt);

endmodule

// File: rtl/led_output_driver.sv
// Command-driven active-low LED driver: accept FSM, tick prescaler, shared PWM
// counter and per-channel logic. Optional breathe mode: LED_BREATHE_EN.
module led_output_driver
    import led_output_driver_pkg::*;
#(
    parameter int NUM_LEDS = 6,
    parameter int CLK_HZ   = 27_000_000,
    parameter int TICK_HZ  = 1000,
    parameter int PWM_BITS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [$clog2(NUM_LEDS)-1:0] cmd_led,
    input  logic [1:0]                  cmd_mode,
    input  logic [PWM_BITS-1:0]         cmd_level,
    input  logic [PERIOD_W-1:0]         cmd_period,
    output logic [NUM_LEDS-1:0]         led_n
);

    localparam int LED_W = $clog2(NUM_LEDS);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    fsm_state_e          state_r;
    fsm_state_e          state_s;
    logic                accept_s;
    logic                cmd_ready_r;
    logic [LED_W-1:0]    cmd_led_r;
    logic [1:0]          cmd_mode_r;
    logic [PWM_BITS-1:0] cmd_level_r;
    logic [PERIOD_W-1:0] cmd_period_r;
    logic [PRE_W-1:0]    prescale_r;
    logic                tick_s;
    logic [PWM_BITS-1:0] pwm_cnt_r;
    logic [NUM_LEDS-1:0] wr_s;
    logic [NUM_LEDS-1:0] lit_s;
    logic [NUM_LEDS-1:0] led_n_r;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next state: one command accepted in IDLE, applied in the following cycle.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_APPLY;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_APPLY: state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Ready is registered and held low throughout reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_ready_r <= 1'b0;
        end else begin
            cmd_ready_r <= (state_s == ST_IDLE);
        end
    end

    // Command latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_led_r    <= '0;
            cmd_mode_r   <= 2'd0;
            cmd_level_r  <= '0;
            cmd_period_r <= '0;
        end else if (accept_s) begin
            cmd_led_r    <= cmd_led;
            cmd_mode_r   <= cmd_mode;
            cmd_level_r  <= cmd_level;
            cmd_period_r <= cmd_period;
        end
    end

    // Timebase prescaler; tick is high in the last count of each interval.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescale_r <= '0;
        end else if (tick_s) begin
            prescale_r <= '0;
        end else begin
            prescale_r <= prescale_r + PRE_W'(1);
        end
    end

    assign tick_s = (prescale_r == PRE_W'(DIV - 1));

    // Free-running PWM counter shared by all channels.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_r <= '0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1);
        end
    end

    // Out-of-range channel indices match no strobe and are dropped.
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
        assign wr_s[i] = (state_r == ST_APPLY) && (cmd_led_r == LED_W'(i));

        led_output_driver_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_channel (
            .clk     (clk),
            .rst_n   (rst_n),
            .tick    (tick_s),
            .pwm_cnt (pwm_cnt_r),
            .wr      (wr_s[i]),
            .mode    (cmd_mode_r),
            .level   (cmd_level_r),
            .period  (cmd_period_r),
            .lit     (lit_s[i])
        );
    end

    // Registered, inverted LED pins.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_n_r <= '1;
        end else begin
            led_n_r <= ~lit_s;
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign led_n     = led_n_r;

endmodule

// File: tb/tb_led_output_driver.sv
// Directed bench for led_output_driver with CLK_HZ=1000, TICK_HZ=100, PWM_BITS=8.
// Expected LED states come from per-channel command records and the cycle count since reset.
module tb_led_output_driver;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_led;
    logic [1:0] cmd_mode;
    logic [7:0] cmd_level;
    logic [9:0] cmd_period;
    logic [5:0] led_n;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int cfg_mode   [6];
    int cfg_level  [6];
    int cfg_period [6];
    int cfg_w      [6];

    led_output_driver #(
        .NUM_LEDS (6),
        .CLK_HZ   (1000),
        .TICK_HZ  (100),
        .PWM_BITS (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_led    (cmd_led),
        .cmd_mode   (cmd_mode),
        .cmd_level  (cmd_level),
        .cmd_period (cmd_period),
        .led_n      (led_n)
    );

    always #5 clk = ~clk;

    // Clock edges since the last reset edge: pwm = cyc%256, prescaler = cyc%10.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Duty of channel ch in the state reached after clock edge n.
    function automatic int exp_duty(input int ch, input int n);
        int l, ep, k, s, m;
        l  = cfg_level[ch];
        ep = (cfg_period[ch] == 0) ? 1 : cfg_period[ch];
        k  = n / 10 - cfg_w[ch] / 10;
        case (cfg_mode[ch])
            0: return 0;
            1: return l;
            2: return (((k / ep) % 2) == 0) ? l : 0;
            default: begin
`ifdef LED_BREATHE_EN
                if (l == 0) return 0;
                s = k / ep;
                m = s % (2 * l);
                return (m <= l) ? m : 2 * l - m;
`else
                s = 0;
                m = 0;
                return l;
`endif
            end
        endcase
    endfunction

    task automatic send_cmd(input int led, input int mode, input int level, input int period);
        int t;
        int acc;
        @(negedge clk);
        cmd_led    = 3'(led);
        cmd_mode   = 2'(mode);
        cmd_level  = 8'(level);
        cmd_period = 10'(period);
        cmd_valid  = 1'b1;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("accept_wait", int'(t < 50), 1);
        @(posedge clk);
        #1 acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (led < 6) begin
            cfg_mode[led]   = mode;
            cfg_level[led]  = level;
            cfg_period[led] = period;
            cfg_w[led]      = acc + 1;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Cycle-by-cycle comparison of all six pins; one comparison per call.
    task automatic check_leds(input string tag, input int ncyc);
        int bad;
        int n;
        logic [5:0] e;
        bad = 0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1 n = cyc - 1;
            for (int ch = 0; ch < 6; ch++) begin
                e[ch] = !(exp_duty(ch, n) > (n % 256));
            end
            if (led_n !== e) bad++;
        end
        chk(tag, bad, 0);
    endtask

    initial begin
        int cnt0;
        int oth;
        int acc_a;
        int acc_c;

        for (int ch = 0; ch < 6; ch++) begin
            cfg_mode[ch] = 0; cfg_level[ch] = 0; cfg_period[ch] = 0; cfg_w[ch] = 0;
        end
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_led = 3'd0; cmd_mode = 2'd0;
        cmd_level = 8'd0; cmd_period = 10'd0;

        // 1. reset state and ready after release
        repeat (5) @(negedge clk);
        chk("reset_led_n", int'(led_n), 32'h3f);
        chk("reset_ready", int'(cmd_ready), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", int'(cmd_ready), 1);

        // 2. ON level 64 on LED 0: lit 64 of every 256 cycles
        send_cmd(0, 1, 64, 0);
        cnt0 = 0; oth = 0;
        for (int c = 0; c < 256; c++) begin
            @(posedge clk);
            #1;
            if (led_n[0] == 1'b0) cnt0++;
            if (led_n[5:1] != 5'h1f) oth++;
        end
        chk("on64_lit_count", cnt0, 64);
        chk("on64_others_dark", oth, 0);
        check_leds("on64_cycles", 256);

        // 3. BLINK level 255 period 3 on LED 1: 30 clk lit / 30 clk dark
        send_cmd(1, 2, 255, 3);
        check_leds("blink_ch1", 360);

        // 4. back-to-back with valid held high; LED 7 is discarded
        @(negedge clk);
        cmd_valid = 1'b1; cmd_led = 3'd3; cmd_mode = 2'd1; cmd_level = 8'd200; cmd_period = 10'd0;
        chk("b2b_ready0", int'(cmd_ready), 1);
        @(posedge clk);
        #1 acc_a = cyc;
        @(negedge clk);
        chk("b2b_ready1", int'(cmd_ready), 0);
        cmd_led = 3'd7; cmd_mode = 2'd1; cmd_level = 8'd255;
        @(negedge clk);
        chk("b2b_ready2", int'(cmd_ready), 1);
        @(negedge clk);
        chk("b2b_ready3", int'(cmd_ready), 0);
        cmd_led = 3'd4; cmd_mode = 2'd2; cmd_level = 8'd128; cmd_period = 10'd0;
        @(negedge clk);
        chk("b2b_ready4", int'(cmd_ready), 1);
        @(posedge clk);
        #1 acc_c = cyc;
        @(negedge clk);
        chk("b2b_ready5", int'(cmd_ready), 0);
        cmd_valid = 1'b0;
        cfg_mode[3] = 1; cfg_level[3] = 200; cfg_period[3] = 0; cfg_w[3] = acc_a + 1;
        cfg_mode[4] = 2; cfg_level[4] = 128; cfg_period[4] = 0; cfg_w[4] = acc_c + 1;
        @(posedge clk);
        @(negedge clk);
        check_leds("b2b_channels", 300);

        // 5. BREATHE level 4 period 1 on LED 2
        send_cmd(2, 3, 4, 1);
        check_leds("breathe_ch2", 2400);

        // 6. reset asserted during the APPLY cycle discards the command
        @(negedge clk);
        cmd_led = 3'd5; cmd_mode = 2'd1; cmd_level = 8'd255; cmd_period = 10'd0; cmd_valid = 1'b1;
        chk("apply_reset_ready", int'(cmd_ready), 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("apply_reset_led_n", int'(led_n), 32'h3f);
        chk("apply_reset_ready0", int'(cmd_ready), 0);
        for (int ch = 0; ch < 6; ch++) begin
            cfg_mode[ch] = 0; cfg_level[ch] = 0; cfg_period[ch] = 0; cfg_w[ch] = 0;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk("apply_reset_ready1", int'(cmd_ready), 1);
        check_leds("after_reset_dark", 300);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
